// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiply unit.
// Optional feature macro used by mul_unit_seq: MUL_ZERO_BYPASS_EN.
package mul_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NIBBLES  = XLEN_DEF / 4;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mul_state_e;

    function automatic logic op_a_signed(input mul_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(input mul_op_e op);
        return (op == OP_MULH);
    endfunction

endpackage

// File: rtl/mul_row_Nx4.sv
// One partial-product row: |A| times a 4-bit multiplier nibble, built from
// XLEN/4 multiplier_4X4 tiles whose products are summed at 4-bit offsets.
module multiplier_4X4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);
    assign p_o = {4'b0000, a_i} * {4'b0000, b_i};
endmodule

module mul_row_Nx4 #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [3:0]      nib_i,
    output logic [XLEN+3:0] row_o
);
    localparam int NIB = XLEN / 4;

    logic [7:0]      prod_s [NIB];
    logic [XLEN+3:0] row_s;

    for (genvar g = 0; g < NIB; g++) begin : g_tile
        multiplier_4X4 u_tile (
            .a_i (a_i[4*g+3:4*g]),
            .b_i (nib_i),
            .p_o (prod_s[g])
        );
    end

    // Adjacent tile products overlap by 4 bits, so they are added, not concatenated.
    always_comb begin
        row_s = '0;
        for (int i = 0; i < NIB; i++) begin
            row_s = row_s + ((XLEN+4)'(prod_s[i]) << (4 * i));
        end
    end

    assign row_o = row_s;

endmodule

// File: rtl/mul_unit_seq.sv
// Iterative RV32M MUL/MULH/MULHSU/MULHU unit, one nibble of the multiplier per cycle.
// Optional: define MUL_ZERO_BYPASS_EN to complete zero-operand requests in one cycle.
module mul_unit_seq
    import mul_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_result,
    output logic [TAG_W-1:0] o_tag
);
    localparam int NIB   = XLEN / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    mul_state_e        state_q,  state_d;
    logic [XLEN-1:0]   a_q,      a_d;
    logic [XLEN-1:0]   b_q,      b_d;
    mul_op_e           op_q,     op_d;
    logic [TAG_W-1:0]  tag_q,    tag_d;
    logic              neg_q,    neg_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              ready_q,  ready_d;
    logic              valid_q,  valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAG_W-1:0]  otag_q,   otag_d;

    logic              a_sgn_s;
    logic              b_sgn_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic [XLEN+3:0]   row_s;
    logic [2*XLEN-1:0] acc_fix_s;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic s);
        return s ? (~x + XLEN'(1)) : x;
    endfunction

    assign a_sgn_s   = op_a_signed(mul_op_e'(i_op)) & i_rs1[XLEN-1];
    assign b_sgn_s   = op_b_signed(mul_op_e'(i_op)) & i_rs2[XLEN-1];
    assign a_mag_s   = magnitude(i_rs1, a_sgn_s);
    assign b_mag_s   = magnitude(i_rs2, b_sgn_s);
    assign acc_fix_s = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;

    // b_q is shifted down each CALC cycle so the current nibble is always b_q[3:0].
    mul_row_Nx4 #(.XLEN(XLEN)) u_row (
        .a_i   (a_q),
        .nib_i (b_q[3:0]),
        .row_o (row_s)
    );

    // Next-state logic; flush overrides every state transition.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        tag_d    = tag_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        valid_d  = valid_q;
        result_d = result_q;
        otag_d   = otag_q;
        if (i_flush) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_d     = a_mag_s;
                        b_d     = b_mag_s;
                        op_d    = mul_op_e'(i_op);
                        tag_d   = i_tag;
                        neg_d   = a_sgn_s ^ b_sgn_s;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ready_d = 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
                        if ((a_mag_s == '0) || (b_mag_s == '0)) begin
                            state_d  = ST_DONE;
                            result_d = '0;
                            otag_d   = i_tag;
                            valid_d  = 1'b1;
                        end else begin
                            state_d = ST_CALC;
                        end
`else
                        state_d = ST_CALC;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_d = acc_q + ((2*XLEN)'(row_s) << {cnt_q, 2'b00});
                    b_d   = b_q >> 3'd4;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = ST_CALC;
                    end
                end
                ST_FIX: begin
                    acc_d    = acc_fix_s;
                    result_d = (op_q == OP_MUL) ? acc_fix_s[XLEN-1:0] : acc_fix_s[2*XLEN-1:XLEN];
                    otag_d   = tag_q;
                    valid_d  = 1'b1;
                    state_d  = ST_DONE;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        valid_d = 1'b0;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_MUL;
            tag_q    <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            result_q <= '0;
            otag_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            otag_q   <= otag_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_tag    = otag_q;

endmodule

// File: tb/tb_mul_unit_seq.sv
// Self-checking bench for mul_unit_seq: vector table, random model ops and corner sequences.
module tb_mul_unit_seq;

`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
    } exp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [1:0]  i_op = 2'b00;
    logic [31:0] i_rs1 = 32'h0;
    logic [31:0] i_rs2 = 32'h0;
    logic [4:0]  i_tag = 5'd0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_result;
    logic [4:0]  o_tag;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[14];

    mul_unit_seq #(.XLEN(32), .TAG_W(5)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_tag    (i_tag),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_tag    (o_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = ((op == 2'b01) || (op == 2'b10)) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance one cycle; scoreboard compares any result consumed at this edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (o_valid && i_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual=%h tag=%0d required=none", o_result, o_tag);
            end else begin
                e = sb.pop_front();
                if ((o_result !== e.res) || (o_tag !== e.tag)) begin
                    errors++;
                    $display("FAIL result actual=%h/%0d required=%h/%0d", o_result, o_tag, e.res, e.tag);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp, input bit push);
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            step();
            n++;
        end
        check("ready_before_issue", {31'h0, o_ready}, 32'h1);
        i_valid = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        i_tag   = tag;
        if (push) sb.push_back('{res: exp, tag: tag});
        step();
        i_valid = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat);
        int lat;
        lat = 1;
        while (!o_valid && lat < 40) begin
            step();
            lat++;
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp);
        issue(op, a, b, tag, exp, 1'b1);
        wait_result((BYP && (a == 32'h0 || b == 32'h0)) ? 1 : 10);
        step();
    endtask

    task automatic kill_mid_calc(input bit use_rst);
        issue(2'b00, 32'h0000_1234, 32'h0000_5678, 5'd3, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) step();
        if (use_rst) i_rst = 1'b1;
        else i_flush = 1'b1;
        step();
        i_rst   = 1'b0;
        i_flush = 1'b0;
        check(use_rst ? "rst_ready" : "flush_ready", {31'h0, o_ready}, 32'h1);
        check(use_rst ? "rst_valid" : "flush_valid", {31'h0, o_valid}, 32'h0);
        for (int i = 0; i < 12; i++) begin
            if (o_valid) check("killed_valid", {31'h0, o_valid}, 32'h0);
            step();
        end
        run_op(2'b11, 32'd3, 32'd5, 5'd11, 32'h0000_0000);
        run_op(2'b00, 32'd3, 32'd5, 5'd12, 32'h0000_000F);
    endtask

    initial begin
        vecs[0]  = '{op: 2'b00, a: 32'd7,          b: 32'd6,          res: 32'h0000_002A};
        vecs[1]  = '{op: 2'b01, a: 32'h8000_0000, b: 32'h8000_0000, res: 32'h4000_0000};
        vecs[2]  = '{op: 2'b01, a: 32'hFFFF_FFFF, b: 32'h0000_0002, res: 32'hFFFF_FFFF};
        vecs[3]  = '{op: 2'b10, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'hFFFF_FFFF};
        vecs[4]  = '{op: 2'b11, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'hFFFF_FFFE};
        vecs[5]  = '{op: 2'b00, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, res: 32'h0000_0001};
        vecs[6]  = '{op: 2'b01, a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF, res: 32'h3FFF_FFFF};
        vecs[7]  = '{op: 2'b10, a: 32'h8000_0000, b: 32'h8000_0000, res: 32'hC000_0000};
        vecs[8]  = '{op: 2'b11, a: 32'h1234_5678, b: 32'h0000_0010, res: 32'h0000_0001};
        vecs[9]  = '{op: 2'b00, a: 32'h1234_5678, b: 32'h0000_0010, res: 32'h2345_6780};
        vecs[10] = '{op: 2'b00, a: 32'hFFFF_FFFD, b: 32'h0000_0005, res: 32'hFFFF_FFF1};
        vecs[11] = '{op: 2'b01, a: 32'hFFFF_FFFD, b: 32'h0000_0005, res: 32'hFFFF_FFFF};
        vecs[12] = '{op: 2'b01, a: 32'hFFFF_FFFD, b: 32'hFFFF_FFFB, res: 32'h0000_0000};
        vecs[13] = '{op: 2'b00, a: 32'h0000_0000, b: 32'h1234_5678, res: 32'h0000_0000};

        step();
        step();
        i_rst = 1'b0;
        check("reset_ready",  {31'h0, o_ready}, 32'h1);
        check("reset_valid",  {31'h0, o_valid}, 32'h0);
        check("reset_result", o_result, 32'h0);
        check("reset_tag",    {27'h0, o_tag}, 32'h0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].res);
        end

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 2'($urandom_range(3, 0));
            a  = $urandom;
            b  = $urandom;
            run_op(op, a, b, 5'(20 + i), model(op, a, b));
        end

        // Backpressure: result held, second request waits for the handshake.
        i_ready = 1'b0;
        issue(2'b00, 32'd7, 32'd6, 5'd9, 32'h0000_002A, 1'b1);
        wait_result(10);
        i_valid = 1'b1;
        i_op    = 2'b11;
        i_rs1   = 32'd3;
        i_rs2   = 32'd5;
        i_tag   = 5'd4;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid",  {31'h0, o_valid}, 32'h1);
            check("hold_result", o_result, 32'h0000_002A);
            check("hold_tag",    {27'h0, o_tag}, 32'd9);
            check("hold_ready",  {31'h0, o_ready}, 32'h0);
            step();
        end
        i_ready = 1'b1;
        step();
        check("post_hs_ready", {31'h0, o_ready}, 32'h1);
        check("post_hs_valid", {31'h0, o_valid}, 32'h0);
        sb.push_back('{res: 32'h0, tag: 5'd4});
        step();
        i_valid = 1'b0;
        check("accepted_after_hs", {31'h0, o_ready}, 32'h0);
        wait_result(10);
        step();

        kill_mid_calc(1'b0);
        kill_mid_calc(1'b1);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_unit_seq.md
# mul_unit_seq

Iterative RV32M multiply unit for the execute stage. It accepts MUL/MULH/MULHSU/MULHU requests over a valid/ready handshake and consumes the products of a row of `multiplier_4X4` tiles: one 32×4 partial row per cycle, scanning the multiplier nibble by nibble. It returns the selected 32-bit half of the 64-bit product, tagged with the destination register, to the writeback arbiter.

## Interface
**Parameters**
- `XLEN`, 32 — operand width; must be a multiple of 4.
- `TAG_W`, 5 — width of the destination tag carried with each request.

**Ports**
- `i_clk` in 1 — the single clock.
- `i_rst` in 1 — reset; synchronous, active-high.
- `i_valid` in 1 — request valid.
- `o_ready` out 1 — unit can accept a request.
- `i_op` in 2 — operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `i_rs1` in XLEN — multiplicand A.
- `i_rs2` in XLEN — multiplier B.
- `i_tag` in TAG_W — destination tag.
- `i_flush` in 1 — pipeline flush; kill the operation in flight.
- `o_valid` out 1 — result valid.
- `i_ready` in 1 — consumer accepts the result.
- `o_result` out XLEN — selected product half.
- `o_tag` out TAG_W — tag of the result.

## Operation
- States:
  - IDLE: `o_ready`=1. On `i_valid`, do all of the following:
    - Latch |A|, |B|, op and tag.
    - Record `neg` = signA XOR signB.
    - Clear the 2·XLEN accumulator and the nibble counter.
    - Go to CALC.
  - CALC: each cycle, `acc += (|A| × B_nibble[k]) << 4k`, where the partial row comes from XLEN/4 tiles. `k` runs 0..XLEN/4−1. After the last nibble, go to FIX.
  - FIX: if `neg`, `acc = ~acc + 1`. Latch the selected half into `o_result`. Go to DONE.
  - DONE: `o_valid`=1. On `i_ready`, go to IDLE.
- Operand signedness:
  - MULH: A and B signed.
  - MULHSU: A signed, B unsigned.
  - MULHU and MUL: both unsigned.
  - MUL's low half is identical for any signedness.
- Magnitude: |x| of a signed operand is the two's complement of x when the MSB is set. |−2^(XLEN−1)| = 2^(XLEN−1) still fits in XLEN unsigned bits.
- Half selection: MUL → `acc[XLEN-1:0]`; all others → `acc[2XLEN-1:XLEN]`.
- Width rules:
  - The partial row is XLEN+4 bits.
  - The accumulator is 2·XLEN bits; carries out of bit 2·XLEN−1 are discarded. None occur with unsigned magnitudes.
- Output hold: `o_result` and `o_tag` stay stable while `o_valid`=1 and `i_ready`=0.
- Handshake: `o_ready` is 1 only in IDLE. A new request is never accepted in the same cycle a result is consumed.
- `i_flush`:
  - In any state, go to IDLE next cycle and deassert `o_valid`. The result is discarded.
  - A flush in IDLE coinciding with `i_valid` drops the request.
  - Flush has priority over all other transitions.

## Timing
- Reset values: state IDLE, `o_ready`=1, `o_valid`=0, `o_result`=0, `o_tag`=0, accumulator 0, counter 0.
- Reset mid-operation behaves like flush: the operation is lost and nothing is emitted.
- Latency (XLEN=32): accept at cycle 0, CALC cycles 1–8, FIX cycle 9, `o_valid` from cycle 10. Throughput is one op per 11 cycles with `i_ready` tied high.
- General latency: XLEN/4 + 2 cycles from accept to `o_valid`.
- All outputs are registered. There is no combinational path from `i_valid` or `i_ready` to `o_ready` or `o_valid`.

## Configuration
- Macro: `MUL_ZERO_BYPASS_EN`.
- Defined: if |A|==0 or |B|==0 at accept, go directly to DONE with `o_result`=0. Latency is then 1 cycle (`o_valid` at cycle 1).
- Undefined: every operation takes the full XLEN/4 + 2 cycles.

## Structure
- Shared package `mul_pkg`:
  - `mul_op_e` enum (MUL, MULH, MULHSU, MULHU).
  - `mul_state_e` enum (IDLE, CALC, FIX, DONE).
  - Constant `NIBBLES` = XLEN/4.
- Sub-module `mul_row_Nx4`:
  - Combinational: XLEN/4 `multiplier_4X4` tiles computing |A| × 4-bit nibble.
  - Tile outputs are summed at 4-bit offsets into an XLEN+4-bit row.
  - Instantiated once.

## Test plan
- MUL 7 × 6, `i_ready`=1 → `o_result`=0x0000002A at cycle 10, `o_tag` echoed.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULH 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. MULHU with the same operands → 0xFFFFFFFE. MUL with the same operands → 0x00000001.
- Backpressure: hold `i_ready`=0 for 5 cycles after `o_valid` → result and tag stable, `o_ready`=0 throughout. A request driven meanwhile is not accepted until the cycle after the handshake.
- `i_flush` at CALC cycle 4 → `o_valid` never asserts, `o_ready`=1 next cycle. A following MULHU 3 × 5 returns 0x00000000 with no residue. Repeat the same sequence with `i_rst` in place of flush.
- `MUL_ZERO_BYPASS_EN` defined: MUL 0 × 0x12345678 → `o_result`=0 at cycle 1. Undefined: the same request → `o_result`=0 at cycle 10.
